dsp_req_scheduler: RTL and testbench

//  Shares one DSP_top multiplier/MAC between two requesters.
//  - Arbitrates requests round-robin.
//  - Drives the DSP start/mode/mac/barrel_shifter/aa/bb/cc inputs.
//  - Enforces the per-mode issue interval: mode0=1, mode1=2, mode2=4 cycles.
//  - Drains the pipeline before any mode/mac change.
//  - Returns each result tagged with the id of the requester that issued it.

---
 rtl/dsp_req_scheduler_if.sv | 40 ++++
 rtl/dsp_req_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_dsp_req_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dsp_req_scheduler_if.sv
// Request / DSP / response bundle shared by dsp_req_scheduler and its requesters.
// The master side drives the requests and the DSP result; the slave is the scheduler.
interface dsp_req_scheduler_if #(
  parameter int N = 16,
  parameter int M = 16
);
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [3:0]           req_mode;
  logic [1:0]           req_mac;
  logic [3:0]           req_bs;
  logic [2*N-1:0]       req_aa;
  logic [2*M-1:0]       req_bb;
  logic [2*(N+M)-1:0]   req_cc;

  logic                 dsp_start;
  logic [1:0]           dsp_mode;
  logic                 dsp_mac;
  logic [1:0]           dsp_barrel_shifter;
  logic [N-1:0]         dsp_aa;
  logic [M-1:0]         dsp_bb;
  logic [N+M-1:0]       dsp_cc;
  logic [N+M-1:0]       dsp_out;

  logic                 rsp_valid;
  logic                 rsp_id;
  logic [N+M-1:0]       rsp_data;

  modport master (
    output req_valid, req_mode, req_mac, req_bs, req_aa, req_bb, req_cc, dsp_out,
    input  req_ready, dsp_start, dsp_mode, dsp_mac, dsp_barrel_shifter,
           dsp_aa, dsp_bb, dsp_cc, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_mode, req_mac, req_bs, req_aa, req_bb, req_cc, dsp_out,
    output req_ready, dsp_start, dsp_mode, dsp_mac, dsp_barrel_shifter,
           dsp_aa, dsp_bb, dsp_cc, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/dsp_req_scheduler.sv
// Two-requester round-robin scheduler for one shared DSP_top, with issue spacing,
// drain-on-mode-change, MAC lock and id-tagged results. Optional: SCHED_PERF_CNT_EN.
module dsp_req_scheduler #(
  parameter int N    = 16,
  parameter int M    = 16,
  parameter int LAT0 = 3,
  parameter int LAT1 = 4,
  parameter int LAT2 = 6
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SCHED_PERF_CNT_EN
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall,
`endif
  dsp_req_scheduler_if.slave bus
);
  localparam int W   = N + M;
  localparam int L01 = (LAT0 > LAT1) ? LAT0 : LAT1;
  localparam int D   = (L01 > LAT2) ? L01 : LAT2;
  localparam int IW  = $clog2(D);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DRAIN} state_t;

  function automatic logic [2:0] interval_of(input logic [1:0] m);
    case (m)
      2'd0:    interval_of = 3'd1;
      2'd1:    interval_of = 3'd2;
      default: interval_of = 3'd4;
    endcase
  endfunction

  function automatic logic [IW-1:0] slot_of(input logic [1:0] m);
    case (m)
      2'd0:    slot_of = IW'(LAT0 - 1);
      2'd1:    slot_of = IW'(LAT1 - 1);
      default: slot_of = IW'(LAT2 - 1);
    endcase
  endfunction

  state_t         state_reg;
  logic [1:0]     cnt_reg;
  logic           rr_ptr_reg;
  logic           lock_reg;
  logic           lock_id_reg;
  logic [D-1:0]   tag_v_reg, tag_v_next;
  logic [D-1:0]   tag_id_reg, tag_id_next;

  logic           dsp_start_reg;
  logic [1:0]     dsp_mode_reg;
  logic           dsp_mac_reg;
  logic [1:0]     dsp_bs_reg;
  logic [N-1:0]   dsp_aa_reg;
  logic [M-1:0]   dsp_bb_reg;
  logic [W-1:0]   dsp_cc_reg;
  logic           rsp_valid_reg;
  logic           rsp_id_reg;
  logic [W-1:0]   rsp_data_reg;

  logic [1:0]     mode_a [2];
  logic           mac_a  [2];
  logic [1:0]     bs_a   [2];
  logic [N-1:0]   aa_a   [2];
  logic [M-1:0]   bb_a   [2];
  logic [W-1:0]   cc_a   [2];
  logic [1:0]     eligible;

  logic           lock_hold;
  logic           window;
  logic           busy;
  logic           cand_any;
  logic           cand_id;
  logic           conflict;
  logic           grant;

  // A held lock only binds while its owner is still asking.
  assign lock_hold = lock_reg && bus.req_valid[lock_id_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign mode_a[gi]        = bus.req_mode[2*gi +: 2];
      assign mac_a[gi]         = bus.req_mac[gi];
      assign bs_a[gi]          = bus.req_bs[2*gi +: 2];
      assign aa_a[gi]          = bus.req_aa[N*gi +: N];
      assign bb_a[gi]          = bus.req_bb[M*gi +: M];
      assign cc_a[gi]          = bus.req_cc[W*gi +: W];
      assign eligible[gi]      = bus.req_valid[gi] && (mode_a[gi] != 2'd3) &&
                                 (!lock_hold || (lock_id_reg == 1'(gi)));
      assign bus.req_ready[gi] = grant && !rst && (cand_id == 1'(gi));
    end
  endgenerate

  // Grants are decided in the last cycle of each issue interval, so back-to-back
  // issues land exactly interval cycles apart.
  assign window   = (state_reg == IDLE) ||
                    ((state_reg == ISSUE) && (interval_of(dsp_mode_reg) == 3'd1)) ||
                    ((state_reg == GAP) && (cnt_reg == 2'd1));
  assign busy     = |tag_v_reg;
  assign cand_any = |eligible;
  assign cand_id  = (eligible == 2'b11) ? rr_ptr_reg : eligible[1];
  assign conflict = cand_any && busy &&
                    ({mode_a[cand_id], mac_a[cand_id]} != {dsp_mode_reg, dsp_mac_reg});
  assign grant    = window && cand_any && !conflict;

  // Tags enter at the slot that makes them reach slot 0 in the cycle dsp_out is valid.
  always_comb begin
    tag_v_next  = {1'b0, tag_v_reg[D-1:1]};
    tag_id_next = {1'b0, tag_id_reg[D-1:1]};
    if (grant) begin
      tag_v_next[slot_of(mode_a[cand_id])]  = 1'b1;
      tag_id_next[slot_of(mode_a[cand_id])] = cand_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rr_ptr_reg    <= 1'b0;
      lock_reg      <= 1'b0;
      lock_id_reg   <= 1'b0;
      tag_v_reg     <= '0;
      tag_id_reg    <= '0;
      dsp_start_reg <= 1'b0;
      dsp_mode_reg  <= '0;
      dsp_mac_reg   <= 1'b0;
      dsp_bs_reg    <= '0;
      dsp_aa_reg    <= '0;
      dsp_bb_reg    <= '0;
      dsp_cc_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      tag_v_reg     <= tag_v_next;
      tag_id_reg    <= tag_id_next;
      dsp_start_reg <= grant;
      rsp_valid_reg <= tag_v_reg[0];
      rsp_id_reg    <= tag_id_reg[0];
      if (tag_v_reg[0]) begin
        rsp_data_reg <= bus.dsp_out;
      end

      if (grant) begin
        dsp_mode_reg <= mode_a[cand_id];
        dsp_mac_reg  <= mac_a[cand_id];
        dsp_bs_reg   <= bs_a[cand_id];
        dsp_aa_reg   <= aa_a[cand_id];
        dsp_bb_reg   <= bb_a[cand_id];
        dsp_cc_reg   <= cc_a[cand_id];
        rr_ptr_reg   <= ~cand_id;
        lock_reg     <= mac_a[cand_id];
        lock_id_reg  <= cand_id;
      end else if (window && lock_reg && !bus.req_valid[lock_id_reg]) begin
        lock_reg <= 1'b0;
      end

      if (window) begin
        if (grant) begin
          state_reg <= ISSUE;
        end else if (conflict) begin
          state_reg <= DRAIN;
        end else begin
          state_reg <= IDLE;
        end
      end else begin
        case (state_reg)
          ISSUE: begin
            state_reg <= GAP;
            cnt_reg   <= 2'(interval_of(dsp_mode_reg) - 3'd1);
          end
          GAP: begin
            cnt_reg <= cnt_reg - 2'd1;
          end
          DRAIN: begin
            if (!busy) begin
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.dsp_start          = dsp_start_reg;
  assign bus.dsp_mode           = dsp_mode_reg;
  assign bus.dsp_mac            = dsp_mac_reg;
  assign bus.dsp_barrel_shifter = dsp_bs_reg;
  assign bus.dsp_aa             = dsp_aa_reg;
  assign bus.dsp_bb             = dsp_bb_reg;
  assign bus.dsp_cc             = dsp_cc_reg;
  assign bus.rsp_valid          = rsp_valid_reg;
  assign bus.rsp_id             = rsp_id_reg;
  assign bus.rsp_data           = rsp_data_reg;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_issued_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued_reg <= '0;
      perf_stall_reg  <= '0;
    end else begin
      perf_issued_reg <= perf_issued_reg + {31'd0, dsp_start_reg};
      perf_stall_reg  <= perf_stall_reg + {31'd0, ((|bus.req_valid) && !grant)};
    end
  end

  assign perf_issued = perf_issued_reg;
  assign perf_stall  = perf_stall_reg;
`endif
endmodule

// File: tb/tb_dsp_req_scheduler.sv
// Directed bench for dsp_req_scheduler with a small DSP_top latency model;
// counter checks are enabled with SCHED_PERF_CNT_EN.
module tb_dsp_req_scheduler;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dsp_req_scheduler_if #(.N(16), .M(16)) bus ();

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  dsp_req_scheduler #(.N(16), .M(16), .LAT0(3), .LAT1(4), .LAT2(6)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef SCHED_PERF_CNT_EN
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall),
`endif
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DSP_top stand-in: result aa*bb+cc shows on dsp_out LAT-1 cycles after dsp_start.
  logic [31:0] dsp_pipe [0:5];
  assign bus.dsp_out = dsp_pipe[0];

  function automatic int model_slot(input logic [1:0] m);
    if (m == 2'd0) return 1;
    if (m == 2'd1) return 2;
    return 4;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 5; k++) dsp_pipe[k] <= dsp_pipe[k+1];
    dsp_pipe[5] <= '0;
    if (bus.dsp_start)
      dsp_pipe[model_slot(bus.dsp_mode)] <= {16'd0, bus.dsp_aa} * {16'd0, bus.dsp_bb} + bus.dsp_cc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input string t, input int k, input logic [1:0] er, input logic es,
                           input logic ev, input logic eid, input logic [31:0] ed);
    chk($sformatf("%s.k%0d.req_ready", t, k), 64'(bus.req_ready), 64'(er));
    chk($sformatf("%s.k%0d.dsp_start", t, k), 64'(bus.dsp_start), 64'(es));
    chk($sformatf("%s.k%0d.rsp_valid", t, k), 64'(bus.rsp_valid), 64'(ev));
    if (ev) begin
      chk($sformatf("%s.k%0d.rsp_id", t, k), 64'(bus.rsp_id), 64'(eid));
      chk($sformatf("%s.k%0d.rsp_data", t, k), 64'(bus.rsp_data), 64'(ed));
    end
    if (bus.rsp_valid)
      $display("%s k=%0d rsp id=%0d data=%0d", t, k, bus.rsp_id, bus.rsp_data);
  endtask

  task automatic drive(input logic [1:0] v,
                       input logic [1:0] m0, input logic c0, input logic [15:0] a0,
                       input logic [15:0] b0, input logic [31:0] cc0,
                       input logic [1:0] m1, input logic c1, input logic [15:0] a1,
                       input logic [15:0] b1, input logic [31:0] cc1);
    bus.req_valid = v;
    bus.req_mode  = {m1, m0};
    bus.req_mac   = {c1, c0};
    bus.req_bs    = 4'b1001;
    bus.req_aa    = {a1, a0};
    bus.req_bb    = {b1, b0};
    bus.req_cc    = {cc1, cc0};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(2'b00, 2'd0, 1'b0, 16'd0, 16'd0, 32'd0, 2'd0, 1'b0, 16'd0, 16'd0, 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < 6; k++) dsp_pipe[k] = '0;

    // Reset: outputs held at zero even with both requesters asking.
    rst = 1'b1;
    drive(2'b11, 2'd0, 1'b1, 16'd7, 16'd9, 32'd1, 2'd0, 1'b0, 16'd7, 16'd9, 32'd1);
    repeat (3) @(posedge clk);
    #2;
    chk("RST.req_ready", 64'(bus.req_ready), 64'd0);
    chk("RST.dsp_start", 64'(bus.dsp_start), 64'd0);
    chk("RST.dsp_aa", 64'(bus.dsp_aa), 64'd0);
    chk("RST.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("RST.rsp_data", 64'(bus.rsp_data), 64'd0);

    // T1: both mode0, alternating grants, one issue per cycle, 3*5 = 15.
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      next_cycle();
      drive((k < 6) ? 2'b11 : 2'b00, 2'd0, 1'b0, 16'd3, 16'd5, 32'd0,
            2'd0, 1'b0, 16'd3, 16'd5, 32'd0);
      #1;
      chk_cycle("T1", k, (k < 6) ? ((k % 2 == 1) ? 2'b10 : 2'b01) : 2'b00,
                (k >= 1 && k <= 6), (k >= 4 && k <= 9), 1'(k % 2), 32'd15);
      if (k == 1) begin
        chk("T1.dsp_barrel_shifter", 64'(bus.dsp_barrel_shifter), 64'd1);
        chk("T1.dsp_aa", 64'(bus.dsp_aa), 64'd3);
      end
    end

    // T2: req0 alone in mode1 for 8 cycles: 4 issues 2 cycles apart, 4*6+2 = 26.
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      next_cycle();
      drive((k < 8) ? 2'b01 : 2'b00, 2'd1, 1'b0, 16'd4, 16'd6, 32'd2,
            2'd0, 1'b0, 16'd0, 16'd0, 32'd0);
      #1;
      chk_cycle("T2", k, (k < 8 && k % 2 == 0) ? 2'b01 : 2'b00,
                (k % 2 == 1 && k <= 7), (k >= 5 && k <= 11 && k % 2 == 1), 1'b0, 32'd26);
      if (k == 1) chk("T2.dsp_mode", 64'(bus.dsp_mode), 64'd1);
    end
`ifdef SCHED_PERF_CNT_EN
    chk("T6.perf_issued", 64'(perf_issued), 64'd4);
    chk("T6.perf_stall", 64'(perf_stall), 64'd4);
`endif

    // T3: mode0 issue then mode2 request: drain, then mode2 issues 4 cycles apart.
    do_reset();
    for (int k = 0; k <= 17; k++) begin
      next_cycle();
      if (k == 0)
        drive(2'b01, 2'd0, 1'b0, 16'd3, 16'd5, 32'd0, 2'd2, 1'b0, 16'd2, 16'd3, 32'd4);
      else if (k <= 9)
        drive(2'b10, 2'd0, 1'b0, 16'd3, 16'd5, 32'd0, 2'd2, 1'b0, 16'd2, 16'd3, 32'd4);
      else
        drive(2'b00, 2'd0, 1'b0, 16'd3, 16'd5, 32'd0, 2'd2, 1'b0, 16'd2, 16'd3, 32'd4);
      #1;
      chk_cycle("T3", k, (k == 0) ? 2'b01 : ((k == 5 || k == 9) ? 2'b10 : 2'b00),
                (k == 1 || k == 6 || k == 10), (k == 4 || k == 12 || k == 16),
                (k != 4), (k == 4) ? 32'd15 : 32'd10);
    end

    // T4: req0 holds the MAC lock for three mac=1 ops; req1 waits until mac=0 issues.
    do_reset();
    for (int k = 0; k <= 13; k++) begin
      next_cycle();
      drive({(k <= 8), (k <= 7)}, 2'd0, (k < 3), 16'd1, 16'd1, 32'd0,
            2'd0, 1'b0, 16'd2, 16'd2, 32'd1);
      #1;
      chk_cycle("T4", k, (k <= 2 || k == 7) ? 2'b01 : ((k == 8) ? 2'b10 : 2'b00),
                (k == 1 || k == 2 || k == 3 || k == 8 || k == 9),
                (k == 4 || k == 5 || k == 6 || k == 11 || k == 12),
                (k == 12), (k == 12) ? 32'd5 : 32'd1);
      if (k == 1) chk("T4.dsp_mac", 64'(bus.dsp_mac), 64'd1);
    end

    // T5: reset with two tags in flight; they never respond, then issue resumes.
    do_reset();
    for (int k = 0; k <= 9; k++) begin
      next_cycle();
      if (k <= 2)
        drive(2'b01, 2'd0, 1'b0, 16'd3, 16'd5, 32'd0, 2'd0, 1'b0, 16'd5, 16'd5, 32'd0);
      else if (k == 4)
        drive(2'b10, 2'd0, 1'b0, 16'd3, 16'd5, 32'd0, 2'd0, 1'b0, 16'd5, 16'd5, 32'd0);
      else
        drive(2'b00, 2'd0, 1'b0, 16'd3, 16'd5, 32'd0, 2'd0, 1'b0, 16'd5, 16'd5, 32'd0);
      if (k == 2) rst = 1'b1;
      if (k == 3) rst = 1'b0;
      #1;
      chk_cycle("T5", k, (k <= 1) ? 2'b01 : ((k == 4) ? 2'b10 : 2'b00),
                (k == 1 || k == 5), (k == 8), 1'b1, 32'd25);
      if (k == 2) begin
        chk("T5.rst.dsp_aa", 64'(bus.dsp_aa), 64'd0);
        chk("T5.rst.dsp_barrel_shifter", 64'(bus.dsp_barrel_shifter), 64'd0);
        chk("T5.rst.rsp_data", 64'(bus.rsp_data), 64'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
